// File: rtl/ldpc_frame_sequencer.sv
// Frame controller ahead of the LDPC decoder array: steers intrinsic words into
// PE memories, holds the decoder enabled for a fixed budget, then streams results.
module ldpc_frame_sequencer #(
   parameter int K             = 6,
   parameter int L             = 32,
   parameter int ADDR_WIDTH    = 5,
   parameter int MESSAGE_WIDTH = 5,
   parameter int MAX_ITER      = 8,
   parameter int ITER_CYCLES   = 64,
   parameter int READ_LAT      = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [MESSAGE_WIDTH-1:0] in_data,
   output logic                     en,
   output logic [K*K-1:0]           pe_select,
   output logic [K-1:0]             column_select,
   output logic [MESSAGE_WIDTH-1:0] int_in,
   output logic [ADDR_WIDTH-1:0]    load_add_in,
   output logic [ADDR_WIDTH-1:0]    read_add_in,
   input  logic [K*K-1:0]           dec_out_fin,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [K*K-1:0]           out_data,
   output logic [ADDR_WIDTH-1:0]    out_addr
);

   localparam int NPE        = K * K;
   localparam int PW         = (NPE > 1) ? $clog2(NPE) : 1;
   localparam int CW         = (K > 1) ? $clog2(K) : 1;
   localparam int DEC_CYCLES = MAX_ITER * ITER_CYCLES;
   localparam int DW         = $clog2(DEC_CYCLES + 1);
   localparam int LW         = $clog2(READ_LAT + 1);

   localparam logic [PW-1:0]         P_LAST   = PW'(NPE - 1);
   localparam logic [CW-1:0]         ROW_LAST = CW'(K - 1);
   localparam logic [ADDR_WIDTH-1:0] A_LAST   = ADDR_WIDTH'(L - 1);
   localparam logic [DW-1:0]         DEC_LAST = DW'(DEC_CYCLES - 1);
   localparam logic [LW-1:0]         LAT_LAST = LW'(READ_LAT);
   localparam logic [NPE-1:0]        PE_ONE   = NPE'(1);
   localparam logic [K-1:0]          COL_ONE  = K'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DECODE,
      S_RD_WAIT,
      S_RD_OUT
   } state_t;

   state_t                   state_q;
   logic [PW-1:0]            p_q;
   logic [CW-1:0]            row_q;
   logic [CW-1:0]            col_q;
   logic [ADDR_WIDTH-1:0]    a_q;
   logic [ADDR_WIDTH-1:0]    r_q;
   logic [DW-1:0]            cyc_q;
   logic [LW-1:0]            lat_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     in_ready_q;
   logic                     en_q;
   logic [NPE-1:0]           pe_select_q;
   logic [K-1:0]             column_select_q;
   logic [MESSAGE_WIDTH-1:0] int_in_q;
   logic [ADDR_WIDTH-1:0]    load_add_in_q;
   logic [ADDR_WIDTH-1:0]    read_add_in_q;
   logic                     out_valid_q;
   logic [NPE-1:0]           out_data_q;
   logic [ADDR_WIDTH-1:0]    out_addr_q;
   logic                     accept_d;

   // in_ready_q is high exactly while in LOAD, so it doubles as the state qualifier.
   assign accept_d = in_valid && in_ready_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         p_q             <= '0;
         row_q           <= '0;
         col_q           <= '0;
         a_q             <= '0;
         r_q             <= '0;
         cyc_q           <= '0;
         lat_q           <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         in_ready_q      <= 1'b0;
         en_q            <= 1'b0;
         pe_select_q     <= '0;
         column_select_q <= '0;
         int_in_q        <= '0;
         load_add_in_q   <= '0;
         read_add_in_q   <= '0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_addr_q      <= '0;
      end else begin
         pe_select_q     <= '0;
         column_select_q <= '0;
         done_q          <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q    <= S_LOAD;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
                  p_q        <= '0;
                  row_q      <= '0;
                  col_q      <= '0;
                  a_q        <= '0;
               end
            end
            S_LOAD: begin
               if (accept_d) begin
                  pe_select_q     <= PE_ONE << p_q;
                  column_select_q <= COL_ONE << col_q;
                  load_add_in_q   <= a_q;
                  int_in_q        <= in_data;
                  if (a_q == A_LAST) begin
                     a_q <= '0;
                     if (p_q == P_LAST) begin
                        state_q    <= S_DECODE;
                        in_ready_q <= 1'b0;
                        cyc_q      <= '0;
                     end else begin
                        p_q <= p_q + 1'b1;
                        // row/col track p without a divider: p = row + col*K
                        if (row_q == ROW_LAST) begin
                           row_q <= '0;
                           col_q <= col_q + 1'b1;
                        end else begin
                           row_q <= row_q + 1'b1;
                        end
                     end
                  end else begin
                     a_q <= a_q + 1'b1;
                  end
               end
            end
            S_DECODE: begin
               // First DECODE cycle carries the final write pulse with en still low.
               if (!en_q) begin
                  en_q <= 1'b1;
               end else if (cyc_q == DEC_LAST) begin
                  en_q          <= 1'b0;
                  state_q       <= S_RD_WAIT;
                  r_q           <= '0;
                  read_add_in_q <= '0;
                  lat_q         <= '0;
               end else begin
                  cyc_q <= cyc_q + 1'b1;
               end
            end
            S_RD_WAIT: begin
               if (lat_q == LAT_LAST) begin
                  out_data_q  <= dec_out_fin;
                  out_addr_q  <= r_q;
                  out_valid_q <= 1'b1;
                  state_q     <= S_RD_OUT;
               end else begin
                  lat_q <= lat_q + 1'b1;
               end
            end
            S_RD_OUT: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  if (r_q == A_LAST) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end else begin
                     r_q           <= r_q + 1'b1;
                     read_add_in_q <= r_q + 1'b1;
                     lat_q         <= '0;
                     state_q       <= S_RD_WAIT;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign in_ready      = in_ready_q;
   assign en            = en_q;
   assign pe_select     = pe_select_q;
   assign column_select = column_select_q;
   assign int_in        = int_in_q;
   assign load_add_in   = load_add_in_q;
   assign read_add_in   = read_add_in_q;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_addr      = out_addr_q;

endmodule
